// File: rtl/uart_pkg.sv
// Shared UART types and helpers: frame configuration enums, TX FSM states,
// baud divisor and data-length decoding.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE    = 2'b00,
    PAR_ODD     = 2'b01,
    PAR_EVEN    = 2'b10,
    PAR_ODD_OUT = 2'b11
  } parity_e;

  typedef enum logic [1:0] {
    BAUD_2400  = 2'b00,
    BAUD_4800  = 2'b01,
    BAUD_9600  = 2'b10,
    BAUD_19200 = 2'b11
  } baud_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP1,
    ST_STOP2
  } tx_state_e;

  localparam int unsigned BAUD_CNT_W = 15;

  // Rounded clocks-per-bit for the selected rate.
  function automatic int unsigned baud_div(input int unsigned clk_hz, input baud_e b);
    int unsigned rate;
    rate = 32'd2400 << b;
    return (clk_hz + rate / 2) / rate;
  endfunction

  function automatic logic [3:0] len_of(input logic [1:0] data_length);
    return 4'd5 + {2'b00, data_length};
  endfunction

endpackage

// File: rtl/uart_tx_frame_if.sv
// Host-side valid/ready handshake and per-word frame configuration for the
// UART transmitter.
interface uart_tx_frame_if #(
  parameter int DATA_W = 8
);
  import uart_pkg::*;

  logic              send;
  logic              ready;
  logic [DATA_W-1:0] data_in;
  baud_e             baud_rate;
  parity_e           parity_type;
  logic              stop_bits;
  logic [1:0]        data_length;

  modport master (
    output send, data_in, baud_rate, parity_type, stop_bits, data_length,
    input  ready
  );

  modport slave (
    input  send, data_in, baud_rate, parity_type, stop_bits, data_length,
    output ready
  );

endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period counter: tick marks the last cycle of each div-cycle bit; clear
// restarts the period so the next cycle is count 0.
module uart_baud_tick
  import uart_pkg::*;
(
  input  logic                  clock,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic [BAUD_CNT_W-1:0] div,
  output logic                  tick
);

  logic [BAUD_CNT_W-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == div - 1'b1);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear || tick) cnt_d = '0;
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_tx_frame.sv
// Buffered UART transmitter: one-deep holding register feeding a single
// shift/FSM engine that serialises start, 5-8 data bits, parity and stop bits.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int DATA_W = 8
) (
  input  logic             clock,
  input  logic             rst_n,
  uart_tx_frame_if.slave   host,
  output logic             data_out,
  output logic             p_parity_out,
  output logic             tx_active,
  output logic             tx_done
);

  localparam int unsigned DIV_2400  = baud_div(CLK_HZ, BAUD_2400);
  localparam int unsigned DIV_4800  = baud_div(CLK_HZ, BAUD_4800);
  localparam int unsigned DIV_9600  = baud_div(CLK_HZ, BAUD_9600);
  localparam int unsigned DIV_19200 = baud_div(CLK_HZ, BAUD_19200);

  if (DIV_2400 >= (1 << BAUD_CNT_W) || DIV_19200 < 1) begin : g_bad_div
    $error("uart_tx_frame: baud divisor does not fit the 15-bit counter");
  end
  if (DATA_W < 8) begin : g_bad_width
    $error("uart_tx_frame: DATA_W must be at least 8");
  end

  function automatic logic [BAUD_CNT_W-1:0] div_sel(input baud_e b);
    logic [BAUD_CNT_W-1:0] r;
    case (b)
      BAUD_2400:  r = BAUD_CNT_W'(DIV_2400);
      BAUD_4800:  r = BAUD_CNT_W'(DIV_4800);
      BAUD_9600:  r = BAUD_CNT_W'(DIV_9600);
      default:    r = BAUD_CNT_W'(DIV_19200);
    endcase
    return r;
  endfunction

  function automatic logic [7:0] len_mask(input logic [1:0] dl);
    return 8'hFF >> (4'd8 - len_of(dl));
  endfunction

  logic                  ready_q, ready_d;
  logic [7:0]            hold_data_q, hold_data_d;
  baud_e                 hold_baud_q, hold_baud_d;
  parity_e               hold_par_q, hold_par_d;
  logic                  hold_stop2_q, hold_stop2_d;
  logic [1:0]            hold_len_q, hold_len_d;

  tx_state_e             state_q, state_d;
  logic [7:0]            shift_q, shift_d;
  logic [2:0]            len_m1_q, len_m1_d;
  parity_e               par_mode_q, par_mode_d;
  logic                  stop2_q, stop2_d;
  logic [BAUD_CNT_W-1:0] div_q, div_d;
  logic [2:0]            bit_cnt_q, bit_cnt_d;
  logic                  par_bit_q, par_bit_d;

  logic                  data_out_q, data_out_d;
  logic                  p_parity_out_q, p_parity_out_d;
  logic                  tx_active_q, tx_active_d;
  logic                  tx_done_q, tx_done_d;

  logic                  accept, load, tick;

  uart_baud_tick u_tick (
    .clock (clock),
    .rst_n (rst_n),
    .clear (load),
    .div   (div_q),
    .tick  (tick)
  );

  always_comb begin
    ready_d        = ready_q;
    hold_data_d    = hold_data_q;
    hold_baud_d    = hold_baud_q;
    hold_par_d     = hold_par_q;
    hold_stop2_d   = hold_stop2_q;
    hold_len_d     = hold_len_q;
    state_d        = state_q;
    shift_d        = shift_q;
    len_m1_d       = len_m1_q;
    par_mode_d     = par_mode_q;
    stop2_d        = stop2_q;
    div_d          = div_q;
    bit_cnt_d      = bit_cnt_q;
    par_bit_d      = par_bit_q;
    p_parity_out_d = p_parity_out_q;
    tx_done_d      = 1'b0;
    load           = 1'b0;

    accept = host.send && ready_q;
    if (accept) begin
      ready_d      = 1'b0;
      hold_data_d  = host.data_in[7:0] & len_mask(host.data_length);
      hold_baud_d  = host.baud_rate;
      hold_par_d   = host.parity_type;
      hold_stop2_d = host.stop_bits;
      hold_len_d   = host.data_length;
    end

    case (state_q)
      ST_IDLE: if (!ready_q) load = 1'b1;
      ST_START: if (tick) begin
        state_d   = ST_DATA;
        bit_cnt_d = '0;
      end
      ST_DATA: if (tick) begin
        shift_d = shift_q >> 1;
        if (bit_cnt_q == len_m1_q)
          state_d = (par_mode_q == PAR_ODD || par_mode_q == PAR_EVEN) ? ST_PARITY : ST_STOP1;
        else
          bit_cnt_d = bit_cnt_q + 1'b1;
      end
      ST_PARITY: if (tick) state_d = ST_STOP1;
      ST_STOP1: if (tick) begin
        if (stop2_q) state_d = ST_STOP2;
        else begin
          state_d   = ST_IDLE;
          tx_done_d = 1'b1;
          load      = !ready_q;
        end
      end
      ST_STOP2: if (tick) begin
        state_d   = ST_IDLE;
        tx_done_d = 1'b1;
        load      = !ready_q;
      end
      default: state_d = ST_IDLE;
    endcase

    // A held word replaces IDLE as the next state, giving a gap-free START.
    if (load) begin
      state_d        = ST_START;
      ready_d        = 1'b1;
      shift_d        = hold_data_q;
      len_m1_d       = 3'(len_of(hold_len_q) - 4'd1);
      par_mode_d     = hold_par_q;
      stop2_d        = hold_stop2_q;
      div_d          = div_sel(hold_baud_q);
      par_bit_d      = (hold_par_q == PAR_EVEN) ? ^hold_data_q : ~^hold_data_q;
      p_parity_out_d = (hold_par_q == PAR_ODD_OUT) && (~^hold_data_q);
    end

    case (state_d)
      ST_START:  data_out_d = 1'b0;
      ST_DATA:   data_out_d = shift_d[0];
      ST_PARITY: data_out_d = par_bit_q;
      default:   data_out_d = 1'b1;
    endcase
    tx_active_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      ready_q        <= 1'b1;
      hold_data_q    <= '0;
      hold_baud_q    <= BAUD_2400;
      hold_par_q     <= PAR_NONE;
      hold_stop2_q   <= 1'b0;
      hold_len_q     <= '0;
      state_q        <= ST_IDLE;
      shift_q        <= '0;
      len_m1_q       <= '0;
      par_mode_q     <= PAR_NONE;
      stop2_q        <= 1'b0;
      div_q          <= '0;
      bit_cnt_q      <= '0;
      par_bit_q      <= 1'b0;
      data_out_q     <= 1'b1;
      p_parity_out_q <= 1'b0;
      tx_active_q    <= 1'b0;
      tx_done_q      <= 1'b0;
    end else begin
      ready_q        <= ready_d;
      hold_data_q    <= hold_data_d;
      hold_baud_q    <= hold_baud_d;
      hold_par_q     <= hold_par_d;
      hold_stop2_q   <= hold_stop2_d;
      hold_len_q     <= hold_len_d;
      state_q        <= state_d;
      shift_q        <= shift_d;
      len_m1_q       <= len_m1_d;
      par_mode_q     <= par_mode_d;
      stop2_q        <= stop2_d;
      div_q          <= div_d;
      bit_cnt_q      <= bit_cnt_d;
      par_bit_q      <= par_bit_d;
      data_out_q     <= data_out_d;
      p_parity_out_q <= p_parity_out_d;
      tx_active_q    <= tx_active_d;
      tx_done_q      <= tx_done_d;
    end
  end

  assign host.ready   = ready_q;
  assign data_out     = data_out_q;
  assign p_parity_out = p_parity_out_q;
  assign tx_active    = tx_active_q;
  assign tx_done      = tx_done_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Scoreboard bench for uart_tx_frame: the driver queues reference frames at
// acceptance, and a line monitor pops and checks every transmitted frame.
module tb_uart_tx_frame;
  import uart_pkg::*;

  localparam int CLK_HZ = 240_000;

  logic clock = 1'b0;
  logic rst_n = 1'b0;
  logic data_out, p_parity_out, tx_active, tx_done;

  uart_tx_frame_if #(.DATA_W(8)) bus ();

  uart_tx_frame #(.CLK_HZ(CLK_HZ), .DATA_W(8)) dut (
    .clock        (clock),
    .rst_n        (rst_n),
    .host         (bus),
    .data_out     (data_out),
    .p_parity_out (p_parity_out),
    .tx_active    (tx_active),
    .tx_done      (tx_done)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [11:0] bits;
    int          nbits;
    int          div;
    logic        ppar;
  } frame_t;

  frame_t exp_q[$];
  int     n_checks = 0;
  int     n_pass   = 0;
  bit     mon_en   = 1'b0;
  int     frame_id = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  function automatic int ref_div(input logic [1:0] b);
    int rate;
    rate = 2400 * (1 << b);
    return (CLK_HZ + rate / 2) / rate;
  endfunction

  // Line image of one frame, bit 0 first on the wire.
  function automatic frame_t ref_frame(input logic [7:0] d, input logic [1:0] b,
                                       input logic [1:0] p, input logic s,
                                       input logic [1:0] l);
    frame_t f;
    int len;
    int ones;
    len     = 5 + int'(l);
    ones    = 0;
    f.bits  = '1;
    f.bits[0] = 1'b0;
    f.nbits = 1;
    for (int i = 0; i < len; i++) begin
      f.bits[f.nbits] = d[i];
      f.nbits++;
      if (d[i]) ones++;
    end
    if (p == 2'b01) begin
      f.bits[f.nbits] = (ones % 2 == 0);
      f.nbits++;
    end else if (p == 2'b10) begin
      f.bits[f.nbits] = (ones % 2 == 1);
      f.nbits++;
    end
    f.nbits += s ? 2 : 1;
    f.div  = ref_div(b);
    f.ppar = (p == 2'b11) && (ones % 2 == 0);
    return f;
  endfunction

  task automatic mon_frame();
    frame_t f;
    int     glitches;
    logic   got;
    bit     abort;
    glitches = 0;
    abort    = 1'b0;
    frame_id++;
    if (exp_q.size() == 0) begin
      chk("unexpected frame", 32'd1, 32'd0);
      while (tx_active === 1'b1 && mon_en) @(negedge clock);
      return;
    end
    f = exp_q.pop_front();
    chk($sformatf("f%0d p_parity_out", frame_id), 32'(p_parity_out), 32'(f.ppar));
    for (int b = 0; b < f.nbits && !abort; b++) begin
      got = f.bits[b];
      for (int c = 0; c < f.div; c++) begin
        if (!mon_en) begin
          abort = 1'b1;
          break;
        end
        if (data_out !== f.bits[b]) got = data_out;
        if (tx_active !== 1'b1 || ((b > 0 || c > 0) && tx_done !== 1'b0)) glitches++;
        @(negedge clock);
      end
      if (!abort) chk($sformatf("f%0d line bit%0d", frame_id, b), 32'(got), 32'(f.bits[b]));
    end
    if (abort) return;
    chk($sformatf("f%0d active/done glitches", frame_id), glitches, 0);
    chk($sformatf("f%0d tx_done pulse", frame_id), 32'(tx_done), 32'd1);
  endtask

  initial begin : monitor
    forever begin
      @(negedge clock);
      while (mon_en && tx_active === 1'b1) mon_frame();
    end
  end

  task automatic scramble();
    bus.data_in     = 8'($urandom);
    bus.baud_rate   = baud_e'($urandom_range(0, 3));
    bus.parity_type = parity_e'($urandom_range(0, 3));
    bus.stop_bits   = 1'($urandom);
    bus.data_length = 2'($urandom);
  endtask

  task automatic send_word(input logic [7:0] d, input logic [1:0] b, input logic [1:0] p,
                           input logic s, input logic [1:0] l, input bit keep, input bit push);
    int t;
    t = 0;
    @(negedge clock);
    bus.data_in     = d;
    bus.baud_rate   = baud_e'(b);
    bus.parity_type = parity_e'(p);
    bus.stop_bits   = s;
    bus.data_length = l;
    bus.send        = 1'b1;
    while (bus.ready !== 1'b1 && t < 20000) begin
      @(negedge clock);
      t++;
    end
    if (t >= 20000) begin
      chk("ready timeout", 32'd0, 32'd1);
      bus.send = 1'b0;
      return;
    end
    @(posedge clock);
    if (push) exp_q.push_back(ref_frame(d, b, p, s, l));
    #1;
    bus.send = keep;
    scramble();
  endtask

  task automatic wait_idle(input string name);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || tx_active !== 1'b0) && t < 40000) begin
      @(negedge clock);
      t++;
    end
    chk(name, exp_q.size(), 0);
  endtask

  initial begin : stimulus
    int  t;
    int  bad;
    bit  keep;
    bus.send = 1'b0;
    scramble();
    rst_n = 1'b0;
    repeat (3) @(negedge clock);
    chk("reset ready", 32'(bus.ready), 32'd1);
    chk("reset data_out", 32'(data_out), 32'd1);
    chk("reset tx_active", 32'(tx_active), 32'd0);
    chk("reset tx_done", 32'(tx_done), 32'd0);
    chk("reset p_parity_out", 32'(p_parity_out), 32'd0);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Accept from idle: one cycle with ready low, then START on the line.
    send_word(8'h6A, 2'b11, 2'b00, 1'b0, 2'b10, 1'b0, 1'b1);
    @(negedge clock);
    chk("k ready", 32'(bus.ready), 32'd0);
    chk("k tx_active", 32'(tx_active), 32'd0);
    chk("k data_out", 32'(data_out), 32'd1);
    @(negedge clock);
    chk("k+1 ready", 32'(bus.ready), 32'd1);
    chk("k+1 tx_active", 32'(tx_active), 32'd1);
    chk("k+1 data_out", 32'(data_out), 32'd0);
    wait_idle("drain 7bit");

    send_word(8'hCA, 2'b11, 2'b01, 1'b1, 2'b11, 1'b0, 1'b1);
    wait_idle("drain odd 2stop");
    send_word(8'hFF, 2'b11, 2'b10, 1'b0, 2'b00, 1'b0, 1'b1);
    wait_idle("drain even 5bit");
    send_word(8'h5A, 2'b11, 2'b11, 1'b0, 2'b11, 1'b0, 1'b1);
    wait_idle("drain parity out");

    // Inputs change while the frame is in flight.
    send_word(8'h33, 2'b10, 2'b01, 1'b0, 2'b01, 1'b0, 1'b1);
    repeat (40) @(negedge clock);
    bus.baud_rate   = BAUD_19200;
    bus.parity_type = PAR_NONE;
    bus.stop_bits   = 1'b1;
    bus.data_length = 2'b00;
    wait_idle("drain config change");

    // Back-to-back with send held high.
    send_word(8'h41, 2'b11, 2'b00, 1'b0, 2'b11, 1'b1, 1'b1);
    send_word(8'h42, 2'b11, 2'b00, 1'b0, 2'b11, 1'b0, 1'b1);
    t = 0;
    while (tx_done !== 1'b1 && t < 5000) begin
      @(negedge clock);
      t++;
    end
    chk("b2b tx_done seen", 32'(tx_done), 32'd1);
    chk("b2b tx_active held", 32'(tx_active), 32'd1);
    chk("b2b zero-gap start", 32'(data_out), 32'd0);
    wait_idle("drain b2b");

    for (int i = 0; i < 24; i++) begin
      keep = ($urandom_range(0, 2) == 0) && (i < 23);
      send_word(8'($urandom), 2'($urandom), 2'($urandom), 1'($urandom), 2'($urandom),
                keep, 1'b1);
      if (!keep) repeat ($urandom_range(0, 40)) @(negedge clock);
    end
    wait_idle("drain random");

    // Reset in the middle of DATA with a second word held.
    mon_en = 1'b0;
    send_word(8'h96, 2'b01, 2'b00, 1'b0, 2'b11, 1'b0, 1'b0);
    send_word(8'h3C, 2'b01, 2'b00, 1'b0, 2'b11, 1'b0, 1'b0);
    repeat (120) @(negedge clock);
    rst_n = 1'b0;
    #1;
    chk("mid reset data_out", 32'(data_out), 32'd1);
    chk("mid reset tx_active", 32'(tx_active), 32'd0);
    chk("mid reset ready", 32'(bus.ready), 32'd1);
    chk("mid reset tx_done", 32'(tx_done), 32'd0);
    @(negedge clock);
    rst_n = 1'b1;
    bad = 0;
    repeat (300) begin
      @(negedge clock);
      if (tx_active !== 1'b0 || data_out !== 1'b1 || bus.ready !== 1'b1 || tx_done !== 1'b0)
        bad++;
    end
    chk("held word discarded", bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
